// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four valid/ready requesters feeding a shared 4:1 mux.
// Grants are bursts of up to BURST_LEN beats into a single registered output stage.
module mux_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  input  logic [4*WIDTH-1:0]   req_data,
  output logic [3:0]           req_ready,
  output logic [1:0]           sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_src,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [3:0]       beat_cnt;
  logic             can_load;
  logic             sel_valid;
  logic             accept;
  logic             last_beat;
  logic             any_valid;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic [WIDTH-1:0] sel_data;

  // Search downward from the farthest offset so the requester nearest rr_ptr wins.
  always_comb begin
    any_valid = |req_valid;
    winner    = rr_ptr;
    idx       = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (req_valid[idx]) winner = idx;
    end
  end

  always_comb begin
    can_load  = !out_valid || out_ready;
    sel_valid = req_valid[sel];
    sel_data  = req_data[sel*WIDTH +: WIDTH];
    accept    = (state == ACTIVE) && sel_valid && can_load;
    last_beat = (beat_cnt == 4'(BURST_LEN - 1));
    req_ready = 4'b0000;
    if (state == ACTIVE && can_load) req_ready[sel] = 1'b1;
  end

  assign busy = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      sel       <= 2'd0;
      beat_cnt  <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            sel      <= winner;
            beat_cnt <= 4'd0;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A dropped valid ends the grant without taking a beat.
          if (!sel_valid) begin
            state  <= IDLE;
            rr_ptr <= sel + 2'd1;
          end else if (can_load) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= sel + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        out_data  <= sel_data;
        out_src   <= sel;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
